// File: rtl/fetch_stage_pkg.sv
// Fetch-stage package: pulls in the shared packet/state types and fetch-wide constants.
`include "sys_defs.svh"

package fetch_stage_pkg;
    localparam int INST_BYTES = 4;
endpackage

// File: rtl/sys_defs.svh
// Shared fetch types: the packet handed to the instruction buffer and the fetch FSM states.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
package sys_defs;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic        valid;
    } FETCH_PACKET;

    typedef enum logic [1:0] {
        FS_REQ     = 2'd0,
        FS_WAIT    = 2'd1,
        FS_DELIVER = 2'd2,
        FS_DRAIN   = 2'd3
    } FETCH_STATE;
endpackage
`endif

// File: rtl/fetch_align.sv
// Lane formation: slices the held line from the PC offset and packs up to
// min(remaining, slots) consecutive instructions into lanes 0..num-1.
module fetch_align
    import sys_defs::*;
    import fetch_stage_pkg::*;
#(
    parameter int PUSH_WIDTH = 4,
    localparam int OW = $clog2(PUSH_WIDTH),
    localparam int CW = $clog2(PUSH_WIDTH + 1)
) (
    input  logic [PUSH_WIDTH-1:0][31:0] i_line,
    input  logic [OW-1:0]               i_offset,
    input  logic [31:0]                 i_pc,
    input  logic [CW-1:0]               i_slots,
    output FETCH_PACKET [PUSH_WIDTH-1:0] o_pkts,
    output logic [CW-1:0]               o_num,
    output logic                        o_last
);
    logic [CW-1:0] w_remaining;

    assign w_remaining = CW'(PUSH_WIDTH) - CW'(i_offset);
    assign o_num       = (i_slots < w_remaining) ? i_slots : w_remaining;
    assign o_last      = (o_num == w_remaining);

    for (genvar i = 0; i < PUSH_WIDTH; i++) begin : g_lane
        logic [OW-1:0] w_idx;
        FETCH_PACKET   w_pkt;

        // Wraps modulo the line, but only lanes below o_num are ever enabled.
        assign w_idx = i_offset + OW'(i);

        always_comb begin
            w_pkt = '0;
            if (CW'(i) < o_num) begin
                w_pkt.inst  = i_line[w_idx];
                w_pkt.PC    = i_pc + 32'(INST_BYTES * i);
                w_pkt.NPC   = i_pc + 32'(INST_BYTES * (i + 1));
                w_pkt.valid = 1'b1;
            end
        end

        assign o_pkts[i] = w_pkt;
    end
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: one-outstanding icache requester feeding the instruction buffer.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall_cycles counters.
module fetch_stage
    import sys_defs::*;
    import fetch_stage_pkg::*;
#(
    parameter int          PUSH_WIDTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    localparam int OW  = $clog2(PUSH_WIDTH),
    localparam int CW  = $clog2(PUSH_WIDTH + 1),
    localparam int LSB = OW + 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        redirect,
    input  logic [31:0]                 redirect_pc,
    output logic                        ic_req_valid,
    output logic [31:0]                 ic_req_addr,
    input  logic                        ic_req_ready,
    input  logic                        ic_resp_valid,
    input  logic [32*PUSH_WIDTH-1:0]    ic_resp_data,
    input  logic [CW-1:0]               available_slots,
    output logic [CW-1:0]               num_pushes,
    output FETCH_PACKET [PUSH_WIDTH-1:0] new_ib_entry
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                 perf_fetched,
    output logic [31:0]                 perf_stall_cycles
`endif
);
    FETCH_STATE                  r_state, w_state_nxt;
    logic [31:0]                 r_pc, w_pc_nxt;
    logic [PUSH_WIDTH-1:0][31:0] r_line;
    logic                        w_line_ld;
    logic                        w_push_en;

    FETCH_PACKET [PUSH_WIDTH-1:0] w_pkts;
    logic [CW-1:0]               w_num;
    logic                        w_last;

    fetch_align #(.PUSH_WIDTH(PUSH_WIDTH)) u_align (
        .i_line   (r_line),
        .i_offset (r_pc[LSB-1:2]),
        .i_pc     (r_pc),
        .i_slots  (available_slots),
        .o_pkts   (w_pkts),
        .o_num    (w_num),
        .o_last   (w_last)
    );

    // Redirect squashes any push in the same cycle it flushes the buffer.
    assign w_push_en    = (r_state == FS_DELIVER) && !redirect;
    assign num_pushes   = w_push_en ? w_num  : '0;
    assign new_ib_entry = w_push_en ? w_pkts : '0;
    assign ic_req_valid = (r_state == FS_REQ);
    assign ic_req_addr  = {r_pc[31:LSB], LSB'(0)};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_line_ld   = 1'b0;
        if (redirect) begin
            w_pc_nxt = redirect_pc;
            case (r_state)
                FS_REQ:     w_state_nxt = ic_req_ready  ? FS_DRAIN : FS_REQ;
                FS_WAIT:    w_state_nxt = ic_resp_valid ? FS_REQ   : FS_DRAIN;
                FS_DELIVER: w_state_nxt = FS_REQ;
                FS_DRAIN:   w_state_nxt = ic_resp_valid ? FS_REQ   : FS_DRAIN;
                default:    w_state_nxt = FS_REQ;
            endcase
        end else begin
            case (r_state)
                FS_REQ:  if (ic_req_ready) w_state_nxt = FS_WAIT;
                FS_WAIT: if (ic_resp_valid) begin
                    w_line_ld   = 1'b1;
                    w_state_nxt = FS_DELIVER;
                end
                FS_DELIVER: begin
                    w_pc_nxt = r_pc + (32'(w_num) << 2);
                    if (w_last) w_state_nxt = FS_REQ;
                end
                FS_DRAIN: if (ic_resp_valid) w_state_nxt = FS_REQ;
                default:  w_state_nxt = FS_REQ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= FS_REQ;
            r_pc    <= RESET_PC;
            r_line  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_line_ld) r_line <= ic_resp_data;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(num_pushes);
            if (r_state == FS_DELIVER && available_slots == '0)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched      = r_perf_fetched;
    assign perf_stall_cycles = r_perf_stall;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, aligned/unaligned fetch, backpressure and redirect races.
module tb_fetch_stage;
    import sys_defs::*;

    localparam int PW = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              ic_req_valid;
    logic [31:0]       ic_req_addr;
    logic              ic_req_ready;
    logic              ic_resp_valid;
    logic [32*PW-1:0]  ic_resp_data;
    logic [2:0]        available_slots;
    logic [2:0]        num_pushes;
    FETCH_PACKET [PW-1:0] new_ib_entry;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage #(.PUSH_WIDTH(PW), .RESET_PC(32'h0)) dut (
        .clock           (clock),
        .reset           (reset),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .ic_req_valid    (ic_req_valid),
        .ic_req_addr     (ic_req_addr),
        .ic_req_ready    (ic_req_ready),
        .ic_resp_valid   (ic_resp_valid),
        .ic_resp_data    (ic_resp_data),
        .available_slots (available_slots),
        .num_pushes      (num_pushes),
        .new_ib_entry    (new_ib_entry)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input logic [31:0] base);
        for (int k = 0; k < PW; k++) ic_resp_data[k*32 +: 32] = base + 32'(k);
    endtask

    // Inputs change at the falling edge; outputs are checked 1ns later, well clear of posedge.
    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
        ic_req_ready = 1'b0; ic_resp_valid = 1'b0; ic_resp_data = '0;
        available_slots = 3'd4;
        step(); #1;
        chk("rst_req_valid", 128'(ic_req_valid), 128'(1));
        chk("rst_req_addr",  128'(ic_req_addr),  128'(0));
        chk("rst_num",       128'(num_pushes),   128'(0));
        chk("rst_entries",   128'(new_ib_entry), 128'(0));
        step(); reset = 1'b0;

        // Aligned line at 0: request, hit next cycle, four pushes, then 0x10.
        step(); ic_req_ready = 1'b1; #1;
        chk("a_req_addr", 128'(ic_req_addr), 128'(0));
        step(); ic_req_ready = 1'b0; ic_resp_valid = 1'b1; set_line(32'h1000); #1;
        chk("a_wait_num", 128'(num_pushes), 128'(0));
        chk("a_wait_req", 128'(ic_req_valid), 128'(0));
        step(); ic_resp_valid = 1'b0; #1;
        chk("a_num",      128'(num_pushes), 128'(4));
        chk("a_pc0",      128'(new_ib_entry[0].PC), 128'(32'h0));
        chk("a_pc3",      128'(new_ib_entry[3].PC), 128'(32'hC));
        chk("a_npc3",     128'(new_ib_entry[3].NPC), 128'(32'h10));
        chk("a_inst1",    128'(new_ib_entry[1].inst), 128'(32'h1001));
        chk("a_valid2",   128'(new_ib_entry[2].valid), 128'(1));
        step(); #1;
        chk("a_next_req", 128'({ic_req_valid, ic_req_addr}), 128'({1'b1, 32'h10}));

        // Unaligned redirect to 0x18 while requesting (not accepted).
        redirect = 1'b1; redirect_pc = 32'h18; #1;
        chk("u_redir_num", 128'(num_pushes), 128'(0));
        step(); redirect = 1'b0; ic_req_ready = 1'b1; #1;
        chk("u_req_addr", 128'(ic_req_addr), 128'(32'h10));
        step(); ic_req_ready = 1'b0; ic_resp_valid = 1'b1; set_line(32'h2000);
        step(); ic_resp_valid = 1'b0; #1;
        chk("u_num",    128'(num_pushes), 128'(2));
        chk("u_pc0",    128'(new_ib_entry[0].PC), 128'(32'h18));
        chk("u_inst0",  128'(new_ib_entry[0].inst), 128'(32'h2002));
        chk("u_pc1",    128'(new_ib_entry[1].PC), 128'(32'h1C));
        chk("u_inst1",  128'(new_ib_entry[1].inst), 128'(32'h2003));
        chk("u_lane2",  128'(new_ib_entry[2]), 128'(0));
        step(); #1;
        chk("u_next_req", 128'({ic_req_valid, ic_req_addr}), 128'({1'b1, 32'h20}));

        // Backpressure over the line at 0x40: slots 0, 1, 3.
        redirect = 1'b1; redirect_pc = 32'h40;
        step(); redirect = 1'b0; ic_req_ready = 1'b1; #1;
        chk("b_req_addr", 128'(ic_req_addr), 128'(32'h40));
        step(); ic_req_ready = 1'b0; ic_resp_valid = 1'b1; set_line(32'h4000);
        step(); ic_resp_valid = 1'b0; available_slots = 3'd0; #1;
        chk("b_num0", 128'(num_pushes), 128'(0));
        chk("b_ent0", 128'(new_ib_entry), 128'(0));
        step(); available_slots = 3'd1; #1;
        chk("b_num1", 128'(num_pushes), 128'(1));
        chk("b_pc_a", 128'(new_ib_entry[0].PC), 128'(32'h40));
        chk("b_inst_a", 128'(new_ib_entry[0].inst), 128'(32'h4000));
        step(); available_slots = 3'd3; #1;
        chk("b_num3", 128'(num_pushes), 128'(3));
        chk("b_pc_b0", 128'(new_ib_entry[0].PC), 128'(32'h44));
        chk("b_pc_b2", 128'(new_ib_entry[2].PC), 128'(32'h4C));
        chk("b_inst_b2", 128'(new_ib_entry[2].inst), 128'(32'h4003));
        step(); available_slots = 3'd4; #1;
        chk("b_next_req", 128'({ic_req_valid, ic_req_addr}), 128'({1'b1, 32'h50}));
`ifdef FETCH_PERF_EN
        chk("b_perf_stall", 128'(perf_stall_cycles), 128'(1));
        chk("b_perf_fetch", 128'(perf_fetched), 128'(10));
`endif

        // Redirect in WAIT; stale response arrives two cycles later.
        ic_req_ready = 1'b1;
        step(); ic_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
        step(); redirect = 1'b0; #1;
        chk("w_drain_req", 128'(ic_req_valid), 128'(0));
        step(); ic_resp_valid = 1'b1; set_line(32'hDEAD0000); #1;
        chk("w_stale_num", 128'(num_pushes), 128'(0));
        step(); ic_resp_valid = 1'b0; #1;
        chk("w_next_req", 128'({ic_req_valid, ic_req_addr}), 128'({1'b1, 32'h80}));
        step(); #1;
        chk("w_no_push", 128'(num_pushes), 128'(0));

        // Redirect coincident with the response.
        ic_req_ready = 1'b1;
        step(); ic_req_ready = 1'b0; ic_resp_valid = 1'b1; redirect = 1'b1; redirect_pc = 32'hC4; #1;
        chk("r_coinc_num", 128'(num_pushes), 128'(0));
        step(); ic_resp_valid = 1'b0; redirect = 1'b0; #1;
        chk("r_next_req", 128'({ic_req_valid, ic_req_addr}), 128'({1'b1, 32'hC0}));

        // Redirect coincident with request accept: drain one response first.
        ic_req_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        step(); ic_req_ready = 1'b0; redirect = 1'b0; #1;
        chk("q_drain_req", 128'(ic_req_valid), 128'(0));
        step(); ic_resp_valid = 1'b1; set_line(32'hBAD0000); #1;
        chk("q_stale_num", 128'(num_pushes), 128'(0));
        step(); ic_resp_valid = 1'b0; #1;
        chk("q_next_req", 128'({ic_req_valid, ic_req_addr}), 128'({1'b1, 32'h100}));
        ic_req_ready = 1'b1;
        step(); ic_req_ready = 1'b0; ic_resp_valid = 1'b1; set_line(32'h5000);
        step(); ic_resp_valid = 1'b0; #1;
        chk("q_num", 128'(num_pushes), 128'(4));
        chk("q_inst0", 128'(new_ib_entry[0].inst), 128'(32'h5000));

        // Redirect during DELIVER squashes the push.
        redirect = 1'b1; redirect_pc = 32'h200; #1;
        chk("d_redir_num", 128'(num_pushes), 128'(0));
        chk("d_redir_ent", 128'(new_ib_entry), 128'(0));
        step(); redirect = 1'b0; #1;
        chk("d_next_req", 128'({ic_req_valid, ic_req_addr}), 128'({1'b1, 32'h200}));

        // Reset in WAIT, then a late response must be ignored.
        ic_req_ready = 1'b1;
        step(); ic_req_ready = 1'b0; reset = 1'b1; #1;
        chk("m_rst_req", 128'({ic_req_valid, ic_req_addr}), 128'({1'b1, 32'h0}));
        step(); reset = 1'b0; ic_resp_valid = 1'b1; set_line(32'h7000);
        step(); ic_resp_valid = 1'b0; #1;
        chk("m_late_req", 128'({ic_req_valid, ic_req_addr}), 128'({1'b1, 32'h0}));
        chk("m_late_num", 128'(num_pushes), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
